// File: rtl/peripheral_uart_irq_pkg.sv
// peripheral_uart_irq_pkg: shared IIR codes, interrupt source indices and the
// RX trigger-level helper for the UART interrupt controller.
// Optional feature macro (consumed by the top): PERIPHERAL_UART_MODEM_IRQ_EN.
package peripheral_uart_irq_pkg;

    localparam logic [3:0] IIR_NONE = 4'b0001;
    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MSI  = 4'b0000;

    // Sources, listed highest priority first.
    typedef enum logic [2:0] {
        SRC_RLS  = 3'd0,
        SRC_RDA  = 3'd1,
        SRC_CTI  = 3'd2,
        SRC_THRE = 3'd3,
        SRC_MSI  = 3'd4
    } irq_src_e;

    localparam int unsigned NUM_SRC = 5;

    // FCR trigger select to RX fill threshold: 1, depth/4, depth/2, depth-2.
    function automatic int unsigned rx_trigger_level(input logic [1:0] sel,
                                                     input int unsigned depth);
        int unsigned lvl;
        case (sel)
            2'd0:    lvl = 1;
            2'd1:    lvl = depth / 4;
            2'd2:    lvl = depth / 2;
            default: lvl = depth - 2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/peripheral_uart_irq_timeout.sv
// peripheral_uart_irq_timeout: character-timeout (CTI) counter and flag.
// Counts character ticks while the RX FIFO holds data and nothing is pushed
// or popped; the flag rises in the same cycle the counter reaches its limit.
module peripheral_uart_irq_timeout #(
    parameter int unsigned TIMEOUT_CHARS = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rx_push_i,
    input  logic rx_pop_i,
    input  logic rx_empty_i,
    input  logic char_tick_i,
    input  logic enable_i,
    output logic cti_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CHARS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CHARS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cti_q, cti_d;
    logic             restart;
    logic             cti_set, cti_clr;

    assign restart = rx_push_i | rx_pop_i | rx_empty_i;

    // Idle character counter, saturating at the timeout limit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (char_tick_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A pop, an empty FIFO or a disabled RDA enable override a pending set.
    assign cti_set = enable_i & (cnt_d == CNT_MAX);
    assign cti_clr = rx_pop_i | rx_empty_i | ~enable_i;
    assign cti_d   = ~cti_clr & (cti_set | cti_q);

    // Counter and flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            cti_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cti_q <= cti_d;
        end
    end

    assign cti_o = cti_q;

endmodule

// File: rtl/peripheral_uart_irq_ctrl.sv
// peripheral_uart_irq_ctrl: 16550-style UART interrupt controller.
// Latches one pending flag per source and presents a prioritised IIR code.
// Optional modem-status interrupt: define PERIPHERAL_UART_MODEM_IRQ_EN.
module peripheral_uart_irq_ctrl
    import peripheral_uart_irq_pkg::*;
#(
    parameter int unsigned TX_FIFO_DEPTH = 32,
    parameter int unsigned RX_FIFO_DEPTH = 32,
    parameter int unsigned TIMEOUT_CHARS = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [3:0]                       ier_i,
    input  logic [1:0]                       trigger_level_i,
    input  logic [$clog2(RX_FIFO_DEPTH):0]   rx_elements_i,
    input  logic [$clog2(TX_FIFO_DEPTH):0]   tx_elements_i,
    input  logic                             rx_push_i,
    input  logic                             rx_pop_i,
    input  logic                             tx_push_i,
    input  logic                             lsr_err_i,
    input  logic                             lsr_rd_i,
    input  logic                             iir_rd_i,
    input  logic                             msr_change_i,
    input  logic                             msr_rd_i,
    input  logic                             char_tick_i,
    output logic                             interrupt_o,
    output logic [3:0]                       iir_o
);

    localparam int unsigned RX_W = $clog2(RX_FIFO_DEPTH) + 1;

    logic [RX_W-1:0]    trig_level;
    logic               rx_trig;
    logic               rx_empty;
    logic               tx_empty;
    logic               rls_q, rls_d;
    logic               rda_q, rda_d;
    logic               thre_q, thre_d;
    logic               tx_empty_q;
    logic               thre_en_q;
    logic               thre_set, thre_clr;
    logic               cti_flag;
    logic               msi_flag;
    logic [NUM_SRC-1:0] pend;
    logic [3:0]         iir_code;

    assign trig_level = RX_W'(rx_trigger_level(trigger_level_i, RX_FIFO_DEPTH));
    assign rx_trig    = rx_elements_i >= trig_level;
    assign rx_empty   = rx_elements_i == '0;
    assign tx_empty   = tx_elements_i == '0;

    // Each set term already includes its IER bit, so a cleared enable drops the flag.
    assign rls_d = ier_i[2] & (lsr_err_i | (rls_q & ~lsr_rd_i));
    assign rda_d = ier_i[0] & rx_trig;

    // THRE fires on a drain to empty or on enabling while already empty.
    assign thre_set = ier_i[1] & tx_empty & (~tx_empty_q | ~thre_en_q);
    assign thre_clr = tx_push_i | (iir_rd_i & (iir_code == IIR_THRE));
    assign thre_d   = ier_i[1] & ~thre_clr & (thre_set | thre_q);

    // Latched source flags plus the edge-detect history for THRE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rls_q      <= 1'b0;
            rda_q      <= 1'b0;
            thre_q     <= 1'b0;
            tx_empty_q <= 1'b1;
            thre_en_q  <= 1'b0;
        end else begin
            rls_q      <= rls_d;
            rda_q      <= rda_d;
            thre_q     <= thre_d;
            tx_empty_q <= tx_empty;
            thre_en_q  <= ier_i[1];
        end
    end

    peripheral_uart_irq_timeout #(
        .TIMEOUT_CHARS (TIMEOUT_CHARS)
    ) u_timeout (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rx_push_i   (rx_push_i),
        .rx_pop_i    (rx_pop_i),
        .rx_empty_i  (rx_empty),
        .char_tick_i (char_tick_i),
        .enable_i    (ier_i[0]),
        .cti_o       (cti_flag)
    );

`ifdef PERIPHERAL_UART_MODEM_IRQ_EN
    logic msi_q, msi_d;

    assign msi_d = ier_i[3] & (msr_change_i | (msi_q & ~msr_rd_i));

    // Modem-status flag; a change pulse beats a same-cycle MSR read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            msi_q <= 1'b0;
        end else begin
            msi_q <= msi_d;
        end
    end

    assign msi_flag = msi_q;
`else
    logic unused_msi;

    assign unused_msi = ^{ier_i[3], msr_change_i, msr_rd_i};
    assign msi_flag   = 1'b0;
`endif

    assign pend[SRC_RLS]  = rls_q;
    assign pend[SRC_RDA]  = rda_q;
    assign pend[SRC_CTI]  = cti_flag;
    assign pend[SRC_THRE] = thre_q;
    assign pend[SRC_MSI]  = msi_flag;

    // Priority encoder over registered flags only.
    always_comb begin
        iir_code = IIR_NONE;
        if (pend[SRC_RLS]) begin
            iir_code = IIR_RLS;
        end else if (pend[SRC_RDA]) begin
            iir_code = IIR_RDA;
        end else if (pend[SRC_CTI]) begin
            iir_code = IIR_CTI;
        end else if (pend[SRC_THRE]) begin
            iir_code = IIR_THRE;
        end else if (pend[SRC_MSI]) begin
            iir_code = IIR_MSI;
        end
    end

    assign iir_o       = iir_code;
    assign interrupt_o = ~iir_code[0];

endmodule

// File: tb/tb_peripheral_uart_irq_ctrl.sv
// tb_peripheral_uart_irq_ctrl: table-driven check of the UART interrupt
// controller (RX depth 16, timeout 4) plus CTI and reset sequences.
// Expected MSI code follows PERIPHERAL_UART_MODEM_IRQ_EN.
module tb_peripheral_uart_irq_ctrl;

`ifdef PERIPHERAL_UART_MODEM_IRQ_EN
    localparam logic [3:0] EXP_MSI = 4'b0000;
`else
    localparam logic [3:0] EXP_MSI = 4'b0001;
`endif

    // Strobe bit positions in the vector table.
    localparam logic [7:0] S_NONE = 8'h00;
    localparam logic [7:0] S_PUSH = 8'h80;
    localparam logic [7:0] S_POP  = 8'h40;
    localparam logic [7:0] S_TXP  = 8'h20;
    localparam logic [7:0] S_LERR = 8'h10;
    localparam logic [7:0] S_LRD  = 8'h08;
    localparam logic [7:0] S_IRD  = 8'h04;
    localparam logic [7:0] S_MCHG = 8'h02;
    localparam logic [7:0] S_MRD  = 8'h01;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [3:0] ier_i = '0;
    logic [1:0] trigger_level_i = 2'd2;
    logic [4:0] rx_elements_i = '0;
    logic [5:0] tx_elements_i = '0;
    logic       rx_push_i = 1'b0;
    logic       rx_pop_i = 1'b0;
    logic       tx_push_i = 1'b0;
    logic       lsr_err_i = 1'b0;
    logic       lsr_rd_i = 1'b0;
    logic       iir_rd_i = 1'b0;
    logic       msr_change_i = 1'b0;
    logic       msr_rd_i = 1'b0;
    logic       char_tick_i = 1'b0;
    logic       interrupt_o;
    logic [3:0] iir_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] ier;
        logic [1:0] trig;
        logic [4:0] rx;
        logic [5:0] tx;
        logic [7:0] strb;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    peripheral_uart_irq_ctrl #(
        .TX_FIFO_DEPTH (32),
        .RX_FIFO_DEPTH (16),
        .TIMEOUT_CHARS (4)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .ier_i           (ier_i),
        .trigger_level_i (trigger_level_i),
        .rx_elements_i   (rx_elements_i),
        .tx_elements_i   (tx_elements_i),
        .rx_push_i       (rx_push_i),
        .rx_pop_i        (rx_pop_i),
        .tx_push_i       (tx_push_i),
        .lsr_err_i       (lsr_err_i),
        .lsr_rd_i        (lsr_rd_i),
        .iir_rd_i        (iir_rd_i),
        .msr_change_i    (msr_change_i),
        .msr_rd_i        (msr_rd_i),
        .char_tick_i     (char_tick_i),
        .interrupt_o     (interrupt_o),
        .iir_o           (iir_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input string n, input logic [3:0] ier,
                                input int trig, input int rx, input int tx,
                                input logic [7:0] strb, input logic [3:0] exp);
        vec_t r;
        r.name = n;
        r.ier  = ier;
        r.trig = 2'(trig);
        r.rx   = 5'(rx);
        r.tx   = 6'(tx);
        r.strb = strb;
        r.exp  = exp;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_strobes(input logic [7:0] s);
        rx_push_i    = s[7];
        rx_pop_i     = s[6];
        tx_push_i    = s[5];
        lsr_err_i    = s[4];
        lsr_rd_i     = s[3];
        iir_rd_i     = s[2];
        msr_change_i = s[1];
        msr_rd_i     = s[0];
    endtask

    task automatic chk(input string n, input logic [3:0] exp);
        checks++;
        if (iir_o !== exp) begin
            failures++;
            $display("FAIL %s: iir_o=%b expected %b", n, iir_o, exp);
        end
        checks++;
        if (interrupt_o !== ~exp[0]) begin
            failures++;
            $display("FAIL %s: interrupt_o=%b expected %b", n, interrupt_o, ~exp[0]);
        end
    endtask

    task automatic tick();
        char_tick_i = 1'b1;
        step();
        char_tick_i = 1'b0;
    endtask

    initial begin
        // Trigger levels (depth 16, sel 2 -> 8).
        vecs.push_back(mk("rx7_below",    4'b0001, 2,  7, 0, S_NONE, 4'b0001));
        vecs.push_back(mk("rx8_trig",     4'b0001, 2,  8, 0, S_NONE, 4'b0100));
        vecs.push_back(mk("rx9_hold",     4'b0001, 2,  9, 0, S_NONE, 4'b0100));
        vecs.push_back(mk("rx7_drop",     4'b0001, 2,  7, 0, S_NONE, 4'b0001));
        // RLS over RDA, read clears, set wins collision.
        vecs.push_back(mk("rls_set",      4'b0101, 2,  8, 0, S_LERR, 4'b0110));
        vecs.push_back(mk("rls_hold",     4'b0101, 2,  8, 0, S_NONE, 4'b0110));
        vecs.push_back(mk("rls_rd",       4'b0101, 2,  8, 0, S_LRD,  4'b0100));
        vecs.push_back(mk("rls_collide",  4'b0101, 2,  8, 0, S_LERR | S_LRD, 4'b0110));
        vecs.push_back(mk("rls_rd2",      4'b0101, 2,  8, 0, S_LRD,  4'b0100));
        // THRE drain, IIR read, re-enable, push collision.
        vecs.push_back(mk("thre_tx1",     4'b0011, 2,  0, 1, S_NONE, 4'b0001));
        vecs.push_back(mk("thre_drain",   4'b0011, 2,  0, 0, S_NONE, 4'b0010));
        vecs.push_back(mk("thre_iir_rd",  4'b0011, 2,  0, 0, S_IRD,  4'b0001));
        vecs.push_back(mk("thre_dis",     4'b0001, 2,  0, 0, S_NONE, 4'b0001));
        vecs.push_back(mk("thre_reen",    4'b0011, 2,  0, 0, S_NONE, 4'b0010));
        vecs.push_back(mk("thre_push",    4'b0011, 2,  0, 0, S_TXP,  4'b0001));
        vecs.push_back(mk("thre_tx1b",    4'b0011, 2,  0, 1, S_NONE, 4'b0001));
        vecs.push_back(mk("thre_pushdrn", 4'b0011, 2,  0, 0, S_TXP,  4'b0001));
        vecs.push_back(mk("thre_stay",    4'b0011, 2,  0, 0, S_NONE, 4'b0001));
        // IER disable drops a latched flag.
        vecs.push_back(mk("rls_set2",     4'b0101, 2,  8, 0, S_LERR, 4'b0110));
        vecs.push_back(mk("rls_ier_off",  4'b0001, 2,  8, 0, S_NONE, 4'b0100));
        // Other trigger selects at their boundaries.
        vecs.push_back(mk("sel0_rx1",     4'b0001, 0,  1, 0, S_NONE, 4'b0100));
        vecs.push_back(mk("sel0_rx0",     4'b0001, 0,  0, 0, S_NONE, 4'b0001));
        vecs.push_back(mk("sel1_rx3",     4'b0001, 1,  3, 0, S_NONE, 4'b0001));
        vecs.push_back(mk("sel1_rx4",     4'b0001, 1,  4, 0, S_NONE, 4'b0100));
        vecs.push_back(mk("sel3_rx13",    4'b0001, 3, 13, 0, S_NONE, 4'b0001));
        vecs.push_back(mk("sel3_rx14",    4'b0001, 3, 14, 0, S_NONE, 4'b0100));
        // Modem status.
        vecs.push_back(mk("msi_set",      4'b1000, 2,  0, 0, S_MCHG, EXP_MSI));
        vecs.push_back(mk("msi_hold",     4'b1000, 2,  0, 0, S_NONE, EXP_MSI));
        vecs.push_back(mk("msi_rd",       4'b1000, 2,  0, 0, S_MRD,  4'b0001));
        vecs.push_back(mk("msi_collide",  4'b1000, 2,  0, 0, S_MCHG | S_MRD, EXP_MSI));
        vecs.push_back(mk("msi_ier_off",  4'b0000, 2,  0, 0, S_NONE, 4'b0001));
        // RDA masks THRE; an IIR read showing RDA leaves THRE pending.
        vecs.push_back(mk("rda_thre_a",   4'b0011, 2,  8, 1, S_NONE, 4'b0100));
        vecs.push_back(mk("rda_thre_b",   4'b0011, 2,  8, 0, S_NONE, 4'b0100));
        vecs.push_back(mk("rda_iir_rd",   4'b0011, 2,  8, 0, S_IRD,  4'b0100));
        vecs.push_back(mk("thre_exposed", 4'b0011, 2,  7, 0, S_NONE, 4'b0010));
        vecs.push_back(mk("thre_iir_rd2", 4'b0011, 2,  7, 0, S_IRD,  4'b0001));

        // Reset state.
        step();
        chk("reset_state", 4'b0001);
        rstn_i = 1'b1;
        step();
        chk("post_reset", 4'b0001);

        foreach (vecs[i]) begin
            ier_i           = vecs[i].ier;
            trigger_level_i = vecs[i].trig;
            rx_elements_i   = vecs[i].rx;
            tx_elements_i   = vecs[i].tx;
            set_strobes(vecs[i].strb);
            step();
            chk(vecs[i].name, vecs[i].exp);
        end
        set_strobes(S_NONE);

        // Character timeout: 3 chars, trigger 8, timeout 4.
        ier_i = 4'b0001; trigger_level_i = 2'd2; rx_elements_i = 5'd3; tx_elements_i = '0;
        rx_push_i = 1'b1;
        step();
        rx_push_i = 1'b0;
        chk("cti_start", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            tick();
            step();
        end
        chk("cti_tick3", 4'b0001);
        tick();
        chk("cti_tick4", 4'b1100);
        step();
        step();
        chk("cti_hold", 4'b1100);
        rx_pop_i = 1'b1; rx_elements_i = 5'd2;
        step();
        rx_pop_i = 1'b0;
        chk("cti_pop_clr", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            tick();
            step();
        end
        rx_pop_i = 1'b1;
        step();
        rx_pop_i = 1'b0;
        tick();
        chk("cti_pop_restart", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            step();
            tick();
        end
        chk("cti_after_pop", 4'b1100);
        rx_elements_i = 5'd0;
        step();
        chk("cti_empty_clr", 4'b0001);

        // Reset with every flag set.
        rx_elements_i = 5'd9; ier_i = 4'b1111; tx_elements_i = '0;
        lsr_err_i = 1'b1; msr_change_i = 1'b1;
        step();
        lsr_err_i = 1'b0; msr_change_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        chk("all_set", 4'b0110);
        #2;
        rstn_i = 1'b0; ier_i = '0; rx_elements_i = '0;
        #1;
        chk("async_reset", 4'b0001);
        step();
        step();
        chk("reset_held", 4'b0001);
        #2;
        rstn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_release", 4'b0001);
        end
        ier_i = 4'b0001; rx_elements_i = 5'd3;
        step();
        chk("no_event", 4'b0001);
        rx_elements_i = 5'd8;
        step();
        chk("new_event", 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peripheral_uart_irq_ctrl.md
# peripheral_uart_irq_ctrl

Parametrised 16550-style interrupt controller for the MPSoC UART, replacing the single-register interrupt block. It keeps one latched pending flag per source: line status, receive data/trigger, character timeout, transmitter empty, and optionally modem status. It drives a prioritised IIR code and the interrupt line to the bus-interface register file. Character timeout is counted here from a per-character tick supplied by the baud generator.

## Interface
- `TX_FIFO_DEPTH`, 32: TX FIFO depth (power of two, ≥4).
- `RX_FIFO_DEPTH`, 32: RX FIFO depth (power of two, ≥4).
- `TIMEOUT_CHARS`, 4: idle character times before CTI (≥1).
- `clk_i` input 1: clock; the single clock of the block.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `ier_i` input 4: IER enables, {MSI, RLS, THRE, RDA}, bits [3:0].
- `trigger_level_i` input 2: FCR RX trigger select.
- `rx_elements_i` input $clog2(RX_FIFO_DEPTH)+1: RX FIFO fill.
- `tx_elements_i` input $clog2(TX_FIFO_DEPTH)+1: TX FIFO fill.
- `rx_push_i` input 1: character written into RX FIFO this cycle.
- `rx_pop_i` input 1: RBR read (RX FIFO pop) this cycle.
- `tx_push_i` input 1: THR write this cycle.
- `lsr_err_i` input 1: pulse for overrun, parity, framing or break.
- `lsr_rd_i` input 1: LSR read strobe.
- `iir_rd_i` input 1: IIR read strobe.
- `msr_change_i` input 1: pulse on any modem-status delta.
- `msr_rd_i` input 1: MSR read strobe.
- `char_tick_i` input 1: one-cycle pulse per character time.
- `interrupt_o` output 1: interrupt request, active-high.
- `iir_o` output 4: IIR[3:0]. Bit0=1 means none pending.

## Operation
- **Trigger levels** select index 0..3 → 1, RX_FIFO_DEPTH/4, RX_FIFO_DEPTH/2, RX_FIFO_DEPTH-2. With depth 16 this gives 1/4/8/14.
- **Trigger comparison** is `rx_elements_i ≥ level`, unsigned, at full input width. It is not an equality compare.
- **RLS flag**: set on `lsr_err_i & ier_i[2]`; cleared by `lsr_rd_i`. Set wins if both occur in the same cycle.
- **RDA flag**: registered copy of `ier_i[0] & (rx_elements_i ≥ level)`. It is level-sensitive and has no explicit clear.
- **CTI timeout counter**:
  - Cleared on `rx_push_i`, on `rx_pop_i`, or whenever `rx_elements_i==0`.
  - Otherwise increments on `char_tick_i`, saturating at TIMEOUT_CHARS.
- **CTI flag**:
  - Set when the counter reaches TIMEOUT_CHARS while `ier_i[0]` is high.
  - Cleared by `rx_pop_i` or when the RX FIFO empties; the clear wins over a same-cycle set.
- **THRE flag**:
  - Set when `ier_i[1]` is high and either `tx_elements_i` transitions nonzero→0, or `ier_i[1]` rises while TX is empty.
  - Cleared by `tx_push_i`.
  - Also cleared by `iir_rd_i` while `iir_o` shows 4'b0010.
  - A clear wins over a same-cycle set.
- **MSI flag**: set on `msr_change_i & ier_i[3]`; cleared by `msr_rd_i`. Set wins on collision.
- **IER disable**: deasserting an IER bit clears the corresponding latched flag at the next edge.
- **Priority encoder** (highest first):
  - RLS → 4'b0110
  - RDA → 4'b0100
  - CTI → 4'b1100
  - THRE → 4'b0010
  - MSI → 4'b0000
  - none → 4'b0001
- `interrupt_o = ~iir_o[0]`.

## Timing
- **Reset values**: all flags 0, counter 0, `iir_o`=4'b0001, `interrupt_o`=0. Reset asserted mid-count drops everything immediately.
- **Flag latency**: flags are registered; an event sampled at edge N is visible on `iir_o`/`interrupt_o` after edge N (1-cycle latency).
- **Output path**: `iir_o` and `interrupt_o` are combinational from the registered flags only. No input reaches them without a register.
- **Clears**: a read strobe at edge N clears the flag after edge N. The next-priority source is presented in the same cycle the flag drops.
- **CTI timing**: CTI asserts 1 cycle after the TIMEOUT_CHARS-th `char_tick_i` following the last push or pop.

## Configuration
- Macro: `PERIPHERAL_UART_MODEM_IRQ_EN`.
- **Defined**: the MSI flag and the MSI priority slot exist as described.
- **Undefined**: the MSI flag is removed, `ier_i[3]`, `msr_change_i` and `msr_rd_i` are ignored, and the MSI code is never produced. All ports remain present.

## Structure
- **Package `peripheral_uart_irq_pkg`**:
  - IIR code localparams (IIR_NONE, IIR_RLS, IIR_RDA, IIR_CTI, IIR_THRE, IIR_MSI).
  - An enum of source indices.
  - A function `rx_trigger_level(sel, depth)`.
- **Sub-module `peripheral_uart_irq_timeout`**:
  - Contains the CTI counter and flag.
  - Counter width $clog2(TIMEOUT_CHARS+1).
  - Parameter TIMEOUT_CHARS.

## Test plan
- **Trigger level**: RX_FIFO_DEPTH=16, sel=2'b10, `ier_i`=4'b0001, fill 7→8 → `iir_o`=4'b0100 one cycle later. Fill 9 → code stays; fill 7 → 4'b0001.
- **Priority**: RLS pulse while RDA pending → `iir_o`=4'b0110. `lsr_rd_i` → 4'b0100 in the next cycle.
- **Character timeout**: TIMEOUT_CHARS=4, 3 chars in FIFO, trigger 8, 4 ticks with no push/pop → 4'b1100. Tick count 3 followed by a pop → no CTI.
- **THRE**: TX drains 1→0 with `ier_i[1]`=1 → 4'b0010. `iir_rd_i` → 4'b0001. Re-enabling `ier_i[1]` while TX is empty → 4'b0010 again. `tx_push_i` plus a drain in the same cycle → stays clear.
- **MSI**: with the macro defined, `msr_change_i` pulse → 4'b0000 and `interrupt_o`=1; `msr_rd_i` clears it. Without the macro → stays 4'b0001.
- **Reset**: `rstn_i` low mid-CTI count with all flags set → asynchronous 4'b0001 and `interrupt_o`=0. After release, no interrupt until a new event.
